// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_pkg
//  Purpose  : Shared state encoding and default timing constants for the
//             switch debouncer and related timed conditioning stages.
//  Revision : 1.0  initial release
// ============================================================================
package debounce_pkg;

    // Default timing parameters
    localparam int DEF_CLK_DIV_BITS = 17;
    localparam int DEF_STABLE_TICKS = 3;

    // Width of the stable-tick counter (holds up to 15)
    localparam int CNT_W = 4;

    // Debouncer state encoding
    localparam logic [1:0] ST_ZERO  = 2'b00;
    localparam logic [1:0] ST_WAIT1 = 2'b01;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_WAIT0 = 2'b11;

    typedef enum logic [1:0] {
        S_ZERO  = ST_ZERO,
        S_WAIT1 = ST_WAIT1,
        S_ONE   = ST_ONE,
        S_WAIT0 = ST_WAIT0
    } state_e;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tick_gen
//  Purpose  : Free-running N-bit divider; tick is high for one cycle each
//             time the divider reads all-ones (period 2^N clocks, first
//             tick on cycle 2^N-1 after reset release).
//  Revision : 1.0  initial release
// ============================================================================
module tick_gen
    import debounce_pkg::*;
#(
    parameter int N = DEF_CLK_DIV_BITS
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [N-1:0] div_q;
    logic [N-1:0] div_d;

    // Next divider value: plain wrap-around increment
    always_comb begin
        div_d = div_q + N'(1);
    end

    // Divider register, never cleared except by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = &div_q;

endmodule : tick_gen
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : switch_debouncer
//  Purpose  : Two-flop synchroniser followed by a tick-paced 4-state bounce
//             filter. Drives a clean registered level and a one-cycle pulse
//             on each qualified rising transition.
//  Options  : SWITCH_DEBOUNCER_FALL_TICK_EN adds db_fall_tick, a one-cycle
//             pulse on each qualified falling transition.
//  Revision : 1.0  initial release
// ============================================================================
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int CLK_DIV_BITS = DEF_CLK_DIV_BITS,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_in,
    output logic db_level,
    output logic db_tick
`ifdef SWITCH_DEBOUNCER_FALL_TICK_EN
    ,
    output logic db_fall_tick
`endif
);

    // Counter reload: the value must survive STABLE_TICKS ticks in WAIT
    localparam logic [CNT_W-1:0] c_cnt_reload = CNT_W'(STABLE_TICKS - 1);

    logic              s1_q, s2_q;
    logic              tick;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              db_level_q, db_level_d;
    logic              db_tick_q, db_tick_d;

    tick_gen #(
        .N (CLK_DIV_BITS)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-stage synchroniser for the asynchronous switch input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sw_in;
            s2_q <= s1_q;
        end
    end

    // Next state / counter; a reverting input beats a tick in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_ZERO: begin
                if (s2_q) begin
                    state_d = S_WAIT1;
                    cnt_d   = c_cnt_reload;
                end
            end
            S_WAIT1: begin
                if (!s2_q) begin
                    state_d = S_ZERO;
                end else if (tick) begin
                    if (cnt_q == '0) begin
                        state_d = S_ONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_ONE: begin
                if (!s2_q) begin
                    state_d = S_WAIT0;
                    cnt_d   = c_cnt_reload;
                end
            end
            S_WAIT0: begin
                if (s2_q) begin
                    state_d = S_ONE;
                end else if (tick) begin
                    if (cnt_q == '0) begin
                        state_d = S_ZERO;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_ZERO;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs align with the state
    always_comb begin
        db_level_d = (state_d == S_ONE) || (state_d == S_WAIT0);
        db_tick_d  = (state_q == S_WAIT1) && (state_d == S_ONE);
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_ZERO;
            cnt_q      <= '0;
            db_level_q <= 1'b0;
            db_tick_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            db_level_q <= db_level_d;
            db_tick_q  <= db_tick_d;
        end
    end

    assign db_level = db_level_q;
    assign db_tick  = db_tick_q;

`ifdef SWITCH_DEBOUNCER_FALL_TICK_EN
    logic db_fall_tick_q, db_fall_tick_d;

    // Falling pulse: only a completed WAIT0 -> ZERO qualifies
    always_comb begin
        db_fall_tick_d = (state_q == S_WAIT0) && (state_d == S_ZERO);
    end

    // Falling pulse register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_fall_tick_q <= 1'b0;
        end else begin
            db_fall_tick_q <= db_fall_tick_d;
        end
    end

    assign db_fall_tick = db_fall_tick_q;
`endif

endmodule : switch_debouncer
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_debouncer
//  Purpose  : Directed self-checking bench for switch_debouncer with a short
//             divider (P = 8 clocks) and STABLE_TICKS = 3.
//  Options  : SWITCH_DEBOUNCER_FALL_TICK_EN enables the db_fall_tick checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_switch_debouncer;

    logic clk;
    logic reset;
    logic sw_in;
    logic db_level;
    logic db_tick;
    logic db_fall_tick;

    int n_cmp  = 0;
    int n_fail = 0;

    switch_debouncer #(
        .CLK_DIV_BITS (3),
        .STABLE_TICKS (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_in        (sw_in),
        .db_level     (db_level),
        .db_tick      (db_tick)
`ifdef SWITCH_DEBOUNCER_FALL_TICK_EN
        ,
        .db_fall_tick (db_fall_tick)
`endif
    );

`ifndef SWITCH_DEBOUNCER_FALL_TICK_EN
    assign db_fall_tick = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact-value comparison
    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Latency window comparison
    task automatic check_lat(input string tag, input int lat);
        n_cmp++;
        assert (lat >= 20 && lat <= 27) else begin
            n_fail++;
            $error("FAIL %s: observed latency %0d expected 20..27", tag, lat);
        end
    endtask

    // Advance one cycle and sample 1 ns after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Run ncyc cycles counting level-high cycles and pulses
    task automatic observe(input int ncyc, output int hi, output int rt, output int ft);
        hi = 0; rt = 0; ft = 0;
        for (int i = 0; i < ncyc; i++) begin
            cyc();
            if (db_level === 1'b1)     hi++;
            if (db_tick === 1'b1)      rt++;
            if (db_fall_tick === 1'b1) ft++;
        end
    endtask

    // Wait (bounded) for db_level to reach target; report latency and pulses
    task automatic wait_level(input logic target, output int lat, output int rt,
                              output int rt_at, output int ft, output int ft_at);
        lat = -1; rt = 0; rt_at = 0; ft = 0; ft_at = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (db_tick === 1'b1)      rt++;
            if (db_fall_tick === 1'b1) ft++;
            if (db_level === target) begin
                lat   = i;
                rt_at = (db_tick === 1'b1) ? 1 : 0;
                ft_at = (db_fall_tick === 1'b1) ? 1 : 0;
                break;
            end
        end
    endtask

    int hi, rt, ft, lat, rt_at, ft_at;

    initial begin
        reset = 1'b1;
        sw_in = 1'b0;
        repeat (3) cyc();
        check("reset_level", db_level, 0);
        check("reset_tick", db_tick, 0);
        check("reset_fall_tick", db_fall_tick, 0);
        reset = 1'b0;

        // 1: quiet input for 100 cycles
        observe(100, hi, rt, ft);
        check("quiet_level_hi_cycles", hi, 0);
        check("quiet_ticks", rt, 0);

        // 3: bounce every 5 cycles, then settle low
        for (int k = 0; k < 12; k++) begin
            sw_in = ~sw_in;
            observe(5, hi, rt, ft);
            check("bounce_level_hi_cycles", hi, 0);
            check("bounce_ticks", rt, 0);
        end
        sw_in = 1'b0;
        observe(40, hi, rt, ft);
        check("bounce_settle_level", hi, 0);
        check("bounce_settle_ticks", rt, 0);

        // 2: clean rising step
        sw_in = 1'b1;
        wait_level(1'b1, lat, rt, rt_at, ft, ft_at);
        check_lat("rise_latency", lat);
        check("rise_tick_count", rt, 1);
        check("rise_tick_coincident", rt_at, 1);
        observe(30, hi, rt, ft);
        check("rise_hold_level", hi, 30);
        check("rise_hold_ticks", rt, 0);

        // 4: short low glitch is rejected
        sw_in = 1'b0;
        observe(3, hi, rt, ft);
        sw_in = 1'b1;
        check("glitch_level_during", hi, 3);
        observe(40, hi, rt, ft);
        check("glitch_level_after", hi, 40);
        check("glitch_ticks", rt, 0);
        check("glitch_fall_ticks", ft, 0);

        // 4/6: sustained fall
        sw_in = 1'b0;
        wait_level(1'b0, lat, rt, rt_at, ft, ft_at);
        check_lat("fall_latency", lat);
        check("fall_rise_ticks", rt, 0);
`ifdef SWITCH_DEBOUNCER_FALL_TICK_EN
        check("fall_tick_count", ft, 1);
        check("fall_tick_coincident", ft_at, 1);
`endif
        observe(20, hi, rt, ft);
        check("fall_hold_level", hi, 0);
        check("fall_hold_fall_ticks", ft, 0);

        // 5: reset while in WAIT1
        sw_in = 1'b1;
        observe(10, hi, rt, ft);
        check("wait1_level", hi, 0);
        #2 reset = 1'b1;
        #1;
        check("wait1_reset_level", db_level, 0);
        check("wait1_reset_tick", db_tick, 0);
        repeat (3) cyc();
        reset = 1'b0;
        wait_level(1'b1, lat, rt, rt_at, ft, ft_at);
        check_lat("post_reset_latency", lat);
        check("post_reset_tick_count", rt, 1);
        check("post_reset_tick_coincident", rt_at, 1);

        // Reset from ONE must clear the level without waiting for a clock edge
        #2 reset = 1'b1;
        #1;
        check("async_reset_level", db_level, 0);
        check("async_reset_tick", db_tick, 0);
        repeat (2) cyc();
        reset = 1'b0;
        sw_in = 1'b0;
        observe(5, hi, rt, ft);
        check("final_level", hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_switch_debouncer
`default_nettype wire
